// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the GMII receive path.
//   rx_state_e    : framer state encoding
//   PREAMBLE_BYTE : 8'h55, SFD_BYTE : 8'hD5
//   CRC_POLY / CRC_INIT / CRC_RESIDUE : reflected Ethernet CRC32 constants
//   SPEED_*       : in-band / cfg_speed encodings
//   crc32_byte()  : one byte step of the reflected CRC32 (LSB first)
package eth_rx_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREAMBLE = 2'd1,
      PAYLOAD  = 2'd2,
      DROP     = 2'd3
   } rx_state_e;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;

   localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
   // Register value after running the CRC over data plus its own FCS.
   localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

   localparam logic [1:0]  SPEED_10      = 2'b00;
   localparam logic [1:0]  SPEED_100     = 2'b01;
   localparam logic [1:0]  SPEED_1000    = 2'b10;

   function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                              input logic [7:0]  data);
      logic [31:0] c;
      c = crc ^ {24'h0, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide reflected CRC32 register.
//   clk, rst_n : clock, asynchronous active-low reset (register -> CRC_INIT)
//   init       : reload CRC_INIT (has priority over en)
//   en         : fold data into the register
//   data       : byte to accumulate
//   crc        : current register value (not inverted)
//   match      : register equals the good-frame residue
module eth_crc32 import eth_rx_pkg::*; (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        init,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [31:0] crc,
   output logic        match
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc <= CRC_INIT;
      end else if (init) begin
         crc <= CRC_INIT;
      end else if (en) begin
         crc <= crc32_byte(crc, data);
      end
   end

   assign match = (crc == CRC_RESIDUE);

endmodule

// File: rtl/gmii_rx_framer.sv
// Receive-side MAC framer on the gmii_rxc domain.
// Decodes in-band link status, assembles nibbles in 10/100 mode, strips
// preamble/SFD (and optionally FCS), checks CRC32 and frame length, and
// emits a single-cycle byte stream with per-frame status. No backpressure.
//   clk, rst_n     : gmii_rxc, asynchronous active-low reset
//   gmii_rxdv/rxer : receive data valid / receive error
//   gmii_rxd       : receive data ([3:0] only in nibble mode)
//   cfg_speed      : speed when in-band status is not used
//   m_tdata/m_tvalid/m_tlast/m_tuser : output beat, m_tuser = frame bad on last
//   link_up/link_speed/full_duplex   : in-band status sampled between frames
//   cnt_ok/cnt_err : wrapping good / bad-or-dropped frame counters
//   dbg_state      : current framer state (rx_state_e encoding)
//
// Handshake: m_tvalid is a one-cycle strobe with no ready; every beat is
// consumed the cycle it is presented. m_tlast marks the final beat of a
// frame and m_tuser is meaningful only alongside m_tlast.
module gmii_rx_framer import eth_rx_pkg::*; #(
   parameter bit STRIP_FCS    = 1'b1,
   parameter bit CHECK_FCS    = 1'b1,
   parameter int MIN_FRAME    = 64,
   parameter int MAX_FRAME    = 1518,
   parameter bit INBAND_SPEED = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        gmii_rxdv,
   input  logic        gmii_rxer,
   input  logic [7:0]  gmii_rxd,
   input  logic [1:0]  cfg_speed,
   output logic [7:0]  m_tdata,
   output logic        m_tvalid,
   output logic        m_tlast,
   output logic        m_tuser,
   output logic        link_up,
   output logic [1:0]  link_speed,
   output logic        full_duplex,
   output logic [31:0] cnt_ok,
   output logic [31:0] cnt_err,
   output logic [1:0]  dbg_state
);

   // The delay buffer hides the 4 FCS bytes when stripping; depth 1 still
   // lets the end-of-frame status ride on the final byte.
   localparam int          DEPTH     = STRIP_FCS ? 5 : 1;
   localparam logic [10:0] DEPTH_CNT = 11'(DEPTH);
   localparam logic [10:0] MIN_CNT   = 11'(MIN_FRAME);
   localparam logic [10:0] MAX_CNT   = 11'(MAX_FRAME);

   // Input register stage
   logic       r_dv;
   logic       r_er;
   logic [7:0] r_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dv <= 1'b0;
         r_er <= 1'b0;
         r_d  <= '0;
      end else begin
         r_dv <= gmii_rxdv;
         r_er <= gmii_rxer;
         r_d  <= gmii_rxd;
      end
   end

   rx_state_e   state, state_d;
   rx_state_e   pre_next;
   logic        byte_mode;
   logic        nib_phase;
   logic [3:0]  nib_lo;
   logic        speed_byte;
   logic        mode_eff;
   logic        byte_vld;
   logic [7:0]  byte_val;
   logic [10:0] byte_cnt;
   logic        rxer_seen;
   logic        drop_silent, drop_silent_d;
   logic [7:0]  dbuf [DEPTH];
   logic [31:0] crc_val;
   logic        crc_match;

   logic frame_start;
   logic push;
   logic emit;
   logic emit_last;
   logic emit_user;
   logic silent_err;

   assign speed_byte = INBAND_SPEED ? (link_speed == SPEED_1000)
                                    : (cfg_speed  == SPEED_1000);

   // The first data cycle of a frame is seen while still in IDLE, so it uses
   // the live speed selection; after that the latched mode holds the frame.
   assign mode_eff = (state == IDLE) ? speed_byte : byte_mode;
   assign byte_vld = r_dv & (mode_eff | nib_phase);
   assign byte_val = mode_eff ? r_d : {r_d[3:0], nib_lo};

   assign dbg_state = state;

   always_comb begin
      if (byte_val == PREAMBLE_BYTE) begin
         pre_next = PREAMBLE;
      end else if (byte_val == SFD_BYTE) begin
         pre_next = PAYLOAD;
      end else begin
         pre_next = DROP;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d       = state;
      drop_silent_d = drop_silent;
      frame_start   = 1'b0;
      push          = 1'b0;
      emit          = 1'b0;
      emit_last     = 1'b0;
      emit_user     = 1'b0;
      silent_err    = 1'b0;
      unique case (state)
         IDLE: begin
            if (r_dv) begin
               frame_start = 1'b1;
               state_d     = PREAMBLE;
               // A byte-mode first byte is already a preamble/SFD candidate.
               if (r_er) begin
                  state_d       = DROP;
                  drop_silent_d = 1'b1;
               end else if (byte_vld) begin
                  state_d       = pre_next;
                  drop_silent_d = 1'b1;
               end
            end
         end
         PREAMBLE: begin
            if (!r_dv) begin
               state_d    = IDLE;
               silent_err = 1'b1;
            end else if (r_er) begin
               state_d       = DROP;
               drop_silent_d = 1'b1;
            end else if (byte_vld) begin
               state_d       = pre_next;
               drop_silent_d = 1'b1;
            end
         end
         PAYLOAD: begin
            if (!r_dv) begin
               state_d = IDLE;
               if (byte_cnt >= DEPTH_CNT) begin
                  emit      = 1'b1;
                  emit_last = 1'b1;
                  emit_user = rxer_seen | (byte_cnt < MIN_CNT) | nib_phase |
                              (CHECK_FCS & ~crc_match);
               end else begin
                  silent_err = 1'b1;
               end
            end else if (byte_vld) begin
               if (byte_cnt == MAX_CNT) begin
                  // Overlength: close the frame on the pending byte; the
                  // error was already reported, so DROP stays quiet.
                  emit          = 1'b1;
                  emit_last     = 1'b1;
                  emit_user     = 1'b1;
                  state_d       = DROP;
                  drop_silent_d = 1'b0;
               end else begin
                  push = 1'b1;
                  emit = (byte_cnt >= DEPTH_CNT);
               end
            end
         end
         DROP: begin
            if (!r_dv) begin
               state_d    = IDLE;
               silent_err = drop_silent;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_mode   <= 1'b0;
         nib_phase   <= 1'b0;
         nib_lo      <= '0;
         byte_cnt    <= '0;
         rxer_seen   <= 1'b0;
         drop_silent <= 1'b0;
         link_up     <= 1'b0;
         link_speed  <= '0;
         full_duplex <= 1'b0;
      end else begin
         drop_silent <= drop_silent_d;
         if (state == IDLE && r_dv) begin
            byte_mode <= speed_byte;
         end
         if (!r_dv || mode_eff) begin
            nib_phase <= 1'b0;
         end else begin
            if (!nib_phase) begin
               nib_lo <= r_d[3:0];
            end
            nib_phase <= ~nib_phase;
         end
         if (state == IDLE && !r_dv && !r_er) begin
            link_up     <= r_d[0];
            link_speed  <= r_d[2:1];
            full_duplex <= r_d[3];
         end
         if (frame_start) begin
            byte_cnt  <= '0;
            rxer_seen <= 1'b0;
         end else if (state == PAYLOAD) begin
            if (r_dv && r_er) begin
               rxer_seen <= 1'b1;
            end
            // Saturates one past MAX_FRAME.
            if (byte_vld && byte_cnt <= MAX_CNT) begin
               byte_cnt <= byte_cnt + 11'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) dbuf[i] <= '0;
      end else if (frame_start || emit_last) begin
         for (int i = 0; i < DEPTH; i++) dbuf[i] <= '0;
      end else if (push) begin
         dbuf[0] <= byte_val;
         for (int i = 1; i < DEPTH; i++) dbuf[i] <= dbuf[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_tdata  <= '0;
         m_tvalid <= 1'b0;
         m_tlast  <= 1'b0;
         m_tuser  <= 1'b0;
         cnt_ok   <= '0;
         cnt_err  <= '0;
      end else begin
         m_tvalid <= emit;
         m_tlast  <= emit_last;
         m_tuser  <= emit_user;
         if (emit) begin
            m_tdata <= dbuf[DEPTH-1];
         end
         if (emit_last && !emit_user) begin
            cnt_ok <= cnt_ok + 32'd1;
         end
         if ((emit_last && emit_user) || silent_err) begin
            cnt_err <= cnt_err + 32'd1;
         end
      end
   end

   // CRC restarts outside PAYLOAD so it covers exactly the bytes after SFD.
   eth_crc32 u_crc (
      .clk   (clk),
      .rst_n (rst_n),
      .init  (state != PAYLOAD),
      .en    (push),
      .data  (byte_val),
      .crc   (crc_val),
      .match (crc_match)
   );

   logic unused_crc;
   assign unused_crc = ^crc_val;

endmodule
